// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: state encoding, widths and the default NOP.
// Also used by the IF/ID register and the hazard unit.
package if_fetch_stage_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   // Fetch FSM state encoding (2-bit, legacy-compatible constants)
   typedef logic [1:0] state_t;
   localparam state_t ST_REQ   = 2'd0;
   localparam state_t ST_WAIT  = 2'd1;
   localparam state_t ST_HOLD  = 2'd2;
   localparam state_t ST_DRAIN = 2'd3;

   localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

   // Next sequential PC, modulo 2^XLEN
   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus.
//   imem_req/imem_addr   : request from the fetch stage (master)
//   imem_ready           : memory accepts the request this cycle
//   imem_rvalid/rdata    : response from memory
interface if_fetch_stage_if;
   import if_fetch_stage_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [ILEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at
// a time, buffers the response and presents it with PC+4 to IF/ID.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   pc_write               : consumer accepts the presented fetch (HOLD only)
//   redirect_valid/target  : branch/jump redirect, target[1:0] forced to 0
//   imem                   : instruction-memory bus (master side)
//   fetch_valid            : pc_plus4_out/instr_out carry a valid fetch
//   pc_plus4_out/instr_out : to IF/ID (0 / NOP_INSTR when not valid)
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pc_write,
   input  logic                  redirect_valid,
   input  logic [XLEN-1:0]       redirect_target,
   if_fetch_stage_if.master      imem,
   output logic                  fetch_valid,
   output logic [XLEN-1:0]       pc_plus4_out,
   output logic [ILEN-1:0]       instr_out
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_load;
   logic            w_req;
   logic            r_fetch_valid;
   logic [XLEN-1:0] r_pcp4_buf;
   logic [ILEN-1:0] r_instr_buf;

   assign w_redirect_pc  = redirect_target & ~XLEN'(3);
   assign w_req          = (r_state == ST_REQ) && !redirect_valid && !reset;
   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_pc;

   assign fetch_valid  = r_fetch_valid;
   assign pc_plus4_out = r_pcp4_buf;
   assign instr_out    = r_instr_buf;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_REQ;
      else       r_state <= w_state_nxt;
   end

   // Next-state, next-PC and buffer-load decode; redirect outranks everything
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      if (redirect_valid) begin
         w_pc_nxt = w_redirect_pc;
         unique case (r_state)
            ST_REQ:   w_state_nxt = ST_REQ;
            // An outstanding request must still be drained unless its
            // response arrives right now.
            ST_WAIT:  w_state_nxt = imem.imem_rvalid ? ST_REQ : ST_DRAIN;
            ST_HOLD:  w_state_nxt = ST_REQ;
            ST_DRAIN: w_state_nxt = imem.imem_rvalid ? ST_REQ : ST_DRAIN;
            default:  w_state_nxt = ST_REQ;
         endcase
      end else begin
         unique case (r_state)
            ST_REQ: begin
               if (w_req && imem.imem_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem.imem_rvalid) begin
                  w_state_nxt = ST_HOLD;
                  w_load      = 1'b1;
               end
            end
            ST_HOLD: begin
               if (pc_write) begin
                  w_state_nxt = ST_REQ;
                  w_pc_nxt    = pc_inc(r_pc);
               end
            end
            ST_DRAIN: begin
               if (imem.imem_rvalid) w_state_nxt = ST_REQ;
            end
            default: w_state_nxt = ST_REQ;
         endcase
      end
   end

   // PC register
   always_ff @(posedge clk) begin
      if (reset) r_pc <= RESET_PC;
      else       r_pc <= w_pc_nxt;
   end

   // Response buffer doubles as the registered IF/ID-facing outputs;
   // it is cleared to NOP/0 whenever the next state is not HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_valid <= 1'b0;
         r_pcp4_buf    <= '0;
         r_instr_buf   <= NOP_INSTR;
      end else begin
         r_fetch_valid <= (w_state_nxt == ST_HOLD);
         if (w_load) begin
            r_pcp4_buf  <= pc_inc(r_pc);
            r_instr_buf <= imem.imem_rdata;
         end else if (w_state_nxt != ST_HOLD) begin
            r_pcp4_buf  <= '0;
            r_instr_buf <= NOP_INSTR;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage. Each table row is one
// clock cycle: inputs are driven at negedge and outputs checked 1 ns later.
module tb_if_fetch_stage;
   import if_fetch_stage_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        rst;
      logic        pw;
      logic        rv;
      logic [31:0] rt;
      logic        rdy;
      logic        rval;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_fv;
      logic [31:0] e_pc4;
      logic [31:0] e_instr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_write;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        fetch_valid;
   logic [31:0] pc_plus4_out;
   logic [31:0] instr_out;

   int checks   = 0;
   int failures = 0;

   vec_t vq[$];

   if_fetch_stage_if u_imem ();

   if_fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .pc_write        (pc_write),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem            (u_imem),
      .fetch_valid     (fetch_valid),
      .pc_plus4_out    (pc_plus4_out),
      .instr_out       (instr_out)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic pw, input logic rv,
                               input logic [31:0] rt, input logic rdy,
                               input logic rval, input logic [31:0] rdata,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_fv, input logic [31:0] e_pc4,
                               input logic [31:0] e_instr);
      vec_t v;
      v.rst = rst; v.pw = pw; v.rv = rv; v.rt = rt; v.rdy = rdy;
      v.rval = rval; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
      v.e_fv = e_fv; v.e_pc4 = e_pc4; v.e_instr = e_instr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic pw, input logic rv,
                        input logic [31:0] rt, input logic rdy,
                        input logic rval, input logic [31:0] rdata);
      reset              = rst;
      pc_write           = pw;
      redirect_valid     = rv;
      redirect_target    = rt;
      u_imem.imem_ready  = rdy;
      u_imem.imem_rvalid = rval;
      u_imem.imem_rdata  = rdata;
   endtask

   initial begin
      // Cycle-by-cycle table; state noted is the state at row start
      vq.push_back(mk(1,0,0,0,0,0,0,            0,32'h0,0,0,NOP));           // reset cycle
      vq.push_back(mk(0,1,0,0,1,0,0,            1,32'h0,0,0,NOP));           // REQ accepted
      vq.push_back(mk(0,1,0,0,1,1,32'h0041_0093, 0,32'h0,0,0,NOP));          // WAIT rvalid
      vq.push_back(mk(0,1,0,0,1,0,0,            0,32'h0,1,32'h4,32'h0041_0093)); // HOLD, consume
      vq.push_back(mk(0,0,0,0,0,0,0,            1,32'h4,0,0,NOP));           // REQ not ready
      vq.push_back(mk(0,0,0,0,0,0,0,            1,32'h4,0,0,NOP));           // addr stable
      vq.push_back(mk(0,0,0,0,1,0,0,            1,32'h4,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,1,32'hAAAA_0001, 0,32'h4,0,0,NOP));
      for (int i = 0; i < 5; i++)                                            // HOLD stall x5
         vq.push_back(mk(0,0,0,0,1,0,0,         0,32'h4,1,32'h8,32'hAAAA_0001));
      vq.push_back(mk(0,1,0,0,1,0,0,            0,32'h4,1,32'h8,32'hAAAA_0001));
      vq.push_back(mk(0,0,0,0,1,0,0,            1,32'h8,0,0,NOP));
      vq.push_back(mk(0,0,1,32'h102,1,0,0,      0,32'h8,0,0,NOP));           // WAIT redirect -> DRAIN
      vq.push_back(mk(0,0,0,0,1,0,0,            0,32'h100,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,1,32'hDEAD_BEEF, 0,32'h100,0,0,NOP));        // stale response
      vq.push_back(mk(0,0,0,0,0,0,0,            1,32'h100,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,0,0,            1,32'h100,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,1,32'h1111_2222, 0,32'h100,0,0,NOP));
      vq.push_back(mk(0,1,1,32'h200,1,0,0,      0,32'h100,1,32'h104,32'h1111_2222)); // HOLD redirect
      vq.push_back(mk(0,0,0,0,0,0,0,            1,32'h200,0,0,NOP));
      vq.push_back(mk(0,0,1,32'h307,1,0,0,      0,32'h200,0,0,NOP));         // REQ redirect
      vq.push_back(mk(0,0,0,0,1,0,0,            1,32'h304,0,0,NOP));
      vq.push_back(mk(0,0,1,32'h400,1,1,32'hBAD0_0001, 0,32'h304,0,0,NOP));  // WAIT redirect+rvalid
      vq.push_back(mk(0,0,0,0,1,0,0,            1,32'h400,0,0,NOP));
      vq.push_back(mk(0,0,1,32'h500,1,0,0,      0,32'h400,0,0,NOP));
      vq.push_back(mk(0,0,1,32'h600,1,0,0,      0,32'h500,0,0,NOP));         // DRAIN re-redirect
      vq.push_back(mk(0,0,1,32'h700,1,1,32'h1234, 0,32'h600,0,0,NOP));
      vq.push_back(mk(0,1,0,0,1,0,0,            1,32'h700,0,0,NOP));         // pc_write ignored
      vq.push_back(mk(0,1,0,0,1,0,0,            0,32'h700,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,1,32'h3333_4444, 0,32'h700,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,1,32'h5555_6666, 0,32'h700,1,32'h704,32'h3333_4444)); // stray rvalid
      vq.push_back(mk(0,0,0,0,1,0,0,            0,32'h700,1,32'h704,32'h3333_4444));
      vq.push_back(mk(0,0,1,32'hFFFF_FFFF,1,0,0, 0,32'h700,1,32'h704,32'h3333_4444));
      vq.push_back(mk(0,0,0,0,1,0,0,            1,32'hFFFF_FFFC,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,1,32'h7777_8888, 0,32'hFFFF_FFFC,0,0,NOP));
      vq.push_back(mk(0,1,0,0,1,0,0,            0,32'hFFFF_FFFC,1,32'h0,32'h7777_8888)); // wrap
      vq.push_back(mk(0,0,1,32'h800,1,0,0,      0,32'h0,0,0,NOP));
      vq.push_back(mk(0,0,0,0,1,0,0,            1,32'h800,0,0,NOP));
      vq.push_back(mk(1,0,0,0,1,0,0,            0,32'h800,0,0,NOP));         // reset in WAIT
      vq.push_back(mk(0,0,0,0,0,1,32'h9999_0000, 1,32'h0,0,0,NOP));          // late response ignored
      vq.push_back(mk(0,0,0,0,0,0,0,            1,32'h0,0,0,NOP));

      drive(1,0,0,0,0,0,0);
      repeat (2) @(posedge clk);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].rst, vq[i].pw, vq[i].rv, vq[i].rt, vq[i].rdy, vq[i].rval, vq[i].rdata);
         #1;
         chk($sformatf("row%0d imem_req", i),     32'(u_imem.imem_req), 32'(vq[i].e_req));
         chk($sformatf("row%0d imem_addr", i),    u_imem.imem_addr,     vq[i].e_addr);
         chk($sformatf("row%0d fetch_valid", i),  32'(fetch_valid),     32'(vq[i].e_fv));
         chk($sformatf("row%0d pc_plus4_out", i), pc_plus4_out,         vq[i].e_pc4);
         chk($sformatf("row%0d instr_out", i),    instr_out,            vq[i].e_instr);
      end

      // Back-to-back zero-wait fetches: 3 cycles per instruction
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(0,0,0,0,1,0,0);
         #1;
         chk($sformatf("seq%0d req", k),  32'(u_imem.imem_req), 32'd1);
         chk($sformatf("seq%0d addr", k), u_imem.imem_addr,     32'(4 * k));
         @(negedge clk);
         drive(0,0,0,0,1,1,32'hC000_0000 | 32'(k));
         #1;
         chk($sformatf("seq%0d wait fv", k), 32'(fetch_valid), 32'd0);
         @(negedge clk);
         drive(0,1,0,0,1,0,0);
         #1;
         chk($sformatf("seq%0d fv", k),    32'(fetch_valid), 32'd1);
         chk($sformatf("seq%0d instr", k), instr_out,        32'hC000_0000 | 32'(k));
         chk($sformatf("seq%0d pc4", k),   pc_plus4_out,     32'(4 * k + 4));
      end

      @(negedge clk);
      drive(0,0,0,0,0,0,0);
      #1;
      chk("seq end addr", u_imem.imem_addr, 32'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
